// File: rtl/triggered_sampler.sv
// Circular capture buffer with mask/value trigger and pre/post-trigger split.
// Optional sample decimation is enabled with `define SAMPLER_DECIMATE_EN.
module triggered_sampler #(
    parameter int WIDTH     = 32,
    parameter int TIME_BITS = 10,
    parameter int DEC_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     in,
    input  logic                 arm,
    input  logic                 abort,
    input  logic [WIDTH-1:0]     trig_mask,
    input  logic [WIDTH-1:0]     trig_value,
    input  logic [TIME_BITS-1:0] post_count,
    output logic                 armed,
    output logic                 triggered,
    output logic                 done,
    output logic                 irq,
    input  logic                 irq_clear,
    input  logic                 rd_en,
    input  logic [TIME_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
`ifdef SAMPLER_DECIMATE_EN
    ,
    input  logic [DEC_BITS-1:0]  decim
`endif
);

    localparam int DEPTH = 1 << TIME_BITS;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFILL,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

`ifndef SAMPLER_DECIMATE_EN
    // Constant divide-by-one: every capture cycle is a strobe.
    logic [DEC_BITS-1:0] decim;
    assign decim = '0;
`endif

    state_t               state;
    logic [WIDTH-1:0]     mem [DEPTH];
    logic [TIME_BITS-1:0] wr_ptr;
    logic [TIME_BITS-1:0] cnt;
    logic [TIME_BITS-1:0] start_addr;
    logic [TIME_BITS-1:0] post_n;
    logic [TIME_BITS-1:0] pre_n;
    logic [DEC_BITS-1:0]  div;

    logic capturing;
    logic strobe;
    logic we;
    logic match;
    logic arm_ok;

    assign capturing = (state == S_PREFILL) || (state == S_ARMED) ||
                       (state == S_POST);
    assign strobe    = (div == '0);
    assign we        = capturing && strobe && !abort;
    assign match     = ((in ^ trig_value) & trig_mask) == '0;
    assign arm_ok    = arm && !abort &&
                       ((state == S_IDLE) || (state == S_DONE));

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_ptr] <= in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            wr_ptr     <= '0;
            cnt        <= '0;
            start_addr <= '0;
            post_n     <= '0;
            pre_n      <= '0;
            div        <= '0;
            armed      <= 1'b0;
            triggered  <= 1'b0;
            done       <= 1'b0;
            irq        <= 1'b0;
            rd_data    <= '0;
        end else begin
            if (irq_clear) begin
                irq <= 1'b0;
            end
            if (abort) begin
                state     <= S_IDLE;
                armed     <= 1'b0;
                triggered <= 1'b0;
                done      <= 1'b0;
            end else if (arm_ok) begin
                post_n    <= post_count;
                // DEPTH-1-post_count in TIME_BITS arithmetic
                pre_n     <= ~post_count;
                cnt       <= '0;
                div       <= '0;
                irq       <= 1'b0;
                done      <= 1'b0;
                triggered <= 1'b0;
                if (post_count == '1) begin
                    state <= S_ARMED;
                    armed <= 1'b1;
                end else begin
                    state <= S_PREFILL;
                    armed <= 1'b0;
                end
            end else if (capturing) begin
                div <= (div >= decim) ? '0 : div + 1'b1;
                if (we) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    case (state)
                        S_PREFILL: begin
                            if (cnt == pre_n - 1'b1) begin
                                state <= S_ARMED;
                                armed <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        S_ARMED: begin
                            if (match) begin
                                armed     <= 1'b0;
                                triggered <= 1'b1;
                                cnt       <= '0;
                                if (post_n == '0) begin
                                    state      <= S_DONE;
                                    done       <= 1'b1;
                                    irq        <= 1'b1;
                                    start_addr <= wr_ptr + 1'b1;
                                end else begin
                                    state <= S_POST;
                                end
                            end
                        end
                        S_POST: begin
                            if (cnt == post_n - 1'b1) begin
                                state      <= S_DONE;
                                done       <= 1'b1;
                                irq        <= 1'b1;
                                start_addr <= wr_ptr + 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                        default: begin
                            state <= state;
                        end
                    endcase
                end
            end
            if (rd_en) begin
                rd_data <= mem[start_addr + rd_addr];
            end
        end
    end

endmodule

// File: tb/tb_triggered_sampler.sv
// Scoreboard bench for triggered_sampler (TIME_BITS=4, WIDTH=8).
// Input is a counter advanced once per clock by the stimulus process.
module tb_triggered_sampler;

    localparam int W  = 8;
    localparam int TB = 4;
    localparam int DB = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [W-1:0]  din;
    logic          arm;
    logic          abort;
    logic [W-1:0]  trig_mask;
    logic [W-1:0]  trig_value;
    logic [TB-1:0] post_count;
    logic          armed;
    logic          triggered;
    logic          done;
    logic          irq;
    logic          irq_clear;
    logic          rd_en;
    logic [TB-1:0] rd_addr;
    logic [W-1:0]  rd_data;
`ifdef SAMPLER_DECIMATE_EN
    logic [DB-1:0] decim;
`endif

    always #5 clk = ~clk;

    triggered_sampler #(
        .WIDTH(W),
        .TIME_BITS(TB),
        .DEC_BITS(DB)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .in(din),
        .arm(arm),
        .abort(abort),
        .trig_mask(trig_mask),
        .trig_value(trig_value),
        .post_count(post_count),
        .armed(armed),
        .triggered(triggered),
        .done(done),
        .irq(irq),
        .irq_clear(irq_clear),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
`ifdef SAMPLER_DECIMATE_EN
        ,
        .decim(decim)
`endif
    );

    int           n_cmp = 0;
    int           n_err = 0;
    logic [W-1:0] exp_q[$];
    logic         rd_v = 1'b0;

    always @(posedge clk) rd_v <= rd_en;

    // Read monitor: one pop per presented read result
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rd_v) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_data: got %h, no expected entry", rd_data);
            end else begin
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    n_err++;
                    $display("FAIL rd_data: got %h, expected %h", rd_data, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        din = din + 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic status(input string name, input logic [3:0] exp);
        logic [3:0] got;
        got = {armed, triggered, done, irq};
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: {armed,trig,done,irq} got %b, expected %b",
                     name, got, exp);
        end
    endtask

    task automatic do_arm(input logic [TB-1:0] pc, input logic [W-1:0] m,
                          input logic [W-1:0] v);
        post_count = pc;
        trig_mask  = m;
        trig_value = v;
        din        = 8'h0F;
        arm        = 1'b1;
        step();
        arm        = 1'b0;
    endtask

    task automatic rd(input logic [TB-1:0] a, input logic [W-1:0] e);
        rd_en   = 1'b1;
        rd_addr = a;
        exp_q.push_back(e);
        step();
    endtask

    task automatic rd_end();
        rd_en = 1'b0;
        step();
        step();
    endtask

    initial begin
        reset_n    = 1'b0;
        din        = '0;
        arm        = 1'b0;
        abort      = 1'b0;
        trig_mask  = '0;
        trig_value = '0;
        post_count = '0;
        irq_clear  = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
`ifdef SAMPLER_DECIMATE_EN
        decim      = '0;
`endif
        run(2);
        status("reset", 4'b0000);
        n_cmp++;
        if (rd_data !== 8'h00) begin
            n_err++;
            $display("FAIL reset rd_data: got %h, expected 00", rd_data);
        end
        reset_n = 1'b1;

        // Basic capture with pre/post split
        do_arm(4'd3, 8'hFF, 8'h20);
        run(11);
        status("t1 prefill", 4'b0000);
        run(1);
        status("t1 armed", 4'b1000);
        run(5);
        status("t1 trig", 4'b0100);
        run(2);
        status("t1 post", 4'b0100);
        run(1);
        status("t1 done", 4'b0111);
        rd(4'd0, 8'h14);
        rd(4'd12, 8'h20);
        rd(4'd15, 8'h23);
        rd_end();

        // Match during prefill is ignored; abort
        do_arm(4'd3, 8'hFF, 8'h12);
        status("t2 rearm", 4'b0000);
        run(12);
        status("t2 armed", 4'b1000);
        run(5);
        status("t2 no trig", 4'b1000);
        abort = 1'b1;
        step();
        abort = 1'b0;
        status("t2 abort", 4'b0000);

        // abort wins over arm in the same cycle
        arm   = 1'b1;
        abort = 1'b1;
        step();
        arm   = 1'b0;
        abort = 1'b0;
        run(13);
        status("abort beats arm", 4'b0000);

        // Zero pre-trigger depth
        do_arm(4'd15, 8'hFF, 8'h10);
        status("t3 armed", 4'b1000);
        run(1);
        status("t3 trig", 4'b0100);
        run(15);
        status("t3 done", 4'b0111);
        rd(4'd0, 8'h10);
        rd(4'd7, 8'h17);
        rd(4'd15, 8'h1F);
        rd_end();

        // irq set beats clear, then clear
        do_arm(4'd15, 8'hFF, 8'h10);
        status("t4 rearm", 4'b1000);
        run(15);
        status("t4 post", 4'b0100);
        irq_clear = 1'b1;
        step();
        status("t4 set wins", 4'b0111);
        step();
        status("t4 clear", 4'b0110);
        irq_clear = 1'b0;

        // All-zero mask with post_count 0
        do_arm(4'd0, 8'h00, 8'h5A);
        status("mask0 rearm", 4'b0000);
        run(14);
        status("mask0 prefill", 4'b0000);
        run(1);
        status("mask0 armed", 4'b1000);
        run(1);
        status("mask0 done", 4'b0111);
        rd(4'd0, 8'h10);
        rd(4'd15, 8'h1F);
        rd_end();

        // Async reset mid-POST
        do_arm(4'd3, 8'hFF, 8'h20);
        run(18);
        status("t5 post", 4'b0100);
        reset_n = 1'b0;
        #1;
        status("t5 async reset", 4'b0000);
        n_cmp++;
        if (rd_data !== 8'h00) begin
            n_err++;
            $display("FAIL t5 rd_data: got %h, expected 00", rd_data);
        end
        #2;
        reset_n = 1'b1;
        do_arm(4'd3, 8'hFF, 8'h20);
        run(20);
        status("t5 done", 4'b0111);
        rd(4'd0, 8'h14);
        rd(4'd12, 8'h20);
        rd(4'd15, 8'h23);
        rd_end();

`ifdef SAMPLER_DECIMATE_EN
        // Decimate by 3: stored 10,13,16,...
        decim = 8'd2;
        do_arm(4'd3, 8'hFF, 8'h11);
        run(60);
        status("t6 no match", 4'b1000);
        abort = 1'b1;
        step();
        abort = 1'b0;
        do_arm(4'd3, 8'hFF, 8'h40);
        run(57);
        status("t6 post", 4'b0100);
        step();
        status("t6 done", 4'b0111);
        rd(4'd0, 8'h1C);
        rd(4'd12, 8'h40);
        rd(4'd15, 8'h49);
        rd_end();
`endif

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: %0d reads never returned, expected 0",
                     exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
